sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
- Upstream neighbour of the round-update logic. Accepts one 512-bit message block as sixteen 32-bit words over a valid/ready handshake.
- Produces the message-schedule word W[t] for rounds t = 0..63, one word per controller `advance` pulse, on `w_data`.
- Exports `round_idx` so the K-constant ROM can produce `k_out` aligned with `w_data`.
- Uses a 16-word sliding window, not a 64-word store.

Parameters:
- WORD_W, 32, schedule word width; fixed by SHA-256, not to be overridden.
- ROUNDS, 64, rounds per block; sets the terminal round count.
- BLOCK_WORDS, 16, message words loaded per block.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins loading a new block. Honoured only in IDLE.
- in_valid  in  1  in_data holds a message word.
- in_data  in  32  message word, big-endian word order, W[0] first.
- in_ready  out  1  block accepts a word this cycle.
- advance  in  1  controller consumed the current w_data; step to the next round.
- w_valid  out  1  w_data/round_idx valid (RUN state).
- w_data  out  32  W[round_idx].
- round_idx  out  6  current round t, 0..63; drives the K ROM address.
- block_done  out  1  one-cycle pulse after round 63 is consumed.

Behaviour:
- Reset values:
  - All outputs 0: in_ready=0, w_valid=0, w_data=0, round_idx=0, block_done=0.
  - State=IDLE, window[0..15]=0, load count=0.
- State machine: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=0, w_valid=0.
  - start=1 -> LOAD next cycle. Any word presented in the same cycle is not accepted.
- LOAD:
  - in_ready=1.
  - A word is accepted when in_valid & in_ready. Accepted words go into window[load_cnt] in arrival order; load_cnt increments.
  - On the 16th acceptance -> RUN next cycle, with round_idx=0 and w_data=window[0]=W[0].
  - Gaps in in_valid are legal.
- RUN:
  - w_valid=1, w_data=window[0], round_idx=t. Outputs are registered and stable until advance.
  - advance=1 with t<63:
    - Window shifts down one word (window[i] <= window[i+1]).
    - window[15] <= W_new, where W_new = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^32.
    - round_idx increments. Each round costs one cycle (advance held high = one round per cycle).
  - advance=1 with t=63 -> DONE. w_valid drops next cycle.
  - Rounds 0..15 therefore emit the loaded words unchanged. Rounds 16..63 emit expanded words.
- sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- DONE: block_done=1 for exactly one cycle, w_valid=0, in_ready=0 -> IDLE.
- Ignored inputs:
  - start outside IDLE, including a start pulse during RUN.
  - advance outside RUN.
  - in_valid outside LOAD.
  - None of these corrupt state.
- Latency:
  - Last word accepted at cycle n -> w_valid=1 at n+1.
  - advance at round 63 in cycle m -> block_done=1 at m+1. Earliest next start honoured at m+2 (IDLE).
- Reset mid-operation: at any state, reset returns the block to the reset values on the next edge. A partially loaded or partially expanded block is discarded, and no block_done is issued.
- Multi-block messages: the controller issues a fresh start per block. No state carries across blocks.

Decomposition:
- sha256_pkg holds:
  - WORD_W, ROUNDS, BLOCK_WORDS constants.
  - The state enum {IDLE, LOAD, RUN, DONE}.
  - sigma0/sigma1 functions, shared with the round-update logic's Sigma functions.
- One sub-module: sha256_w_expand, purely combinational. Inputs are window[0], window[1], window[9], window[14]; output is W_new.
  - Kept separate so it can later adopt a CSA adder tree independently.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, in_ready=0. in_valid pulses during this window are ignored (load_cnt stays 0).
- Load "abc" padded block: W0=0x61626380, W1..W14=0, W15=0x00000018, with advance held high.
  - Rounds 0..15 -> exact words loaded.
  - round_idx=16 -> w_data=0x61626380; round_idx=17 -> 0x000F0000.
  - All 64 words match the software model.
  - block_done exactly 1 cycle after round 63.
- Random in_valid gaps during load and random advance stalls -> w_data and round_idx hold while advance=0; the W sequence matches the model.
- start and in_valid asserted in the same IDLE cycle -> that word is not accepted. The next 16 accepted words form the block.
- Assert reset at round 30 -> next cycle all outputs 0 and state IDLE, no block_done. A following block produces the correct schedule.
- Two back-to-back blocks with start at the earliest legal cycle -> second block's W[0..63] correct; block_done pulses twice.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, schedule FSM state encoding and the sigma/Sigma mixing functions.
// Used by the message schedule and the round-update logic.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int ROUNDS      = 64;
  localparam int BLOCK_WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Message-schedule small sigmas.
  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  // Compression-round big sigmas, kept beside the small ones so both blocks share one source.
  function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational schedule expansion: W[t+16] from the four window taps it depends on.
// Isolated so the adder chain can later be swapped for a carry-save tree.
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] i_w0,
  input  logic [WORD_W-1:0] i_w1,
  input  logic [WORD_W-1:0] i_w9,
  input  logic [WORD_W-1:0] i_w14,
  output logic [WORD_W-1:0] o_w_new
);

  logic [WORD_W-1:0] w_s0;
  logic [WORD_W-1:0] w_s1;

  assign w_s0    = sigma0(i_w1);
  assign w_s1    = sigma1(i_w14);
  assign o_w_new = w_s1 + i_w9 + w_s0 + i_w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 16-word block, then emits W[0..63] one word per advance
// using a 16-word sliding window whose head is always the current W[t].
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [WORD_W-1:0] i_in_data,
  output logic              o_in_ready,
  input  logic              i_advance,
  output logic              o_w_valid,
  output logic [WORD_W-1:0] o_w_data,
  output logic [5:0]        o_round_idx,
  output logic              o_block_done
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | accepting 16 message words into the window
  // RUN   | presenting W[t]; advance steps t and slides the window
  // DONE  | one-cycle block_done pulse, then back to IDLE

  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam int RND_W = $clog2(ROUNDS);

  state_t            r_state;
  logic [WORD_W-1:0] r_window [BLOCK_WORDS];
  logic [CNT_W-1:0]  r_load_cnt;
  logic [RND_W-1:0]  r_round;

  logic              w_accept;
  logic              w_step;
  logic              w_last_load;
  logic              w_last_round;
  logic              w_run;
  logic [WORD_W-1:0] w_new;

  sha256_w_expand u_w_expand (
    .i_w0    (r_window[0]),
    .i_w1    (r_window[1]),
    .i_w9    (r_window[9]),
    .i_w14   (r_window[14]),
    .o_w_new (w_new)
  );

  assign w_run        = (r_state == ST_RUN);
  assign w_accept     = (r_state == ST_LOAD) && i_in_valid;
  assign w_step       = w_run && i_advance;
  assign w_last_load  = (r_load_cnt == CNT_W'(BLOCK_WORDS - 1));
  assign w_last_round = (r_round == RND_W'(ROUNDS - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_load_cnt <= '0;
      r_round    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_LOAD;
            r_load_cnt <= '0;
            r_round    <= '0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_load_cnt <= r_load_cnt + CNT_W'(1);
            if (w_last_load) begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (i_advance) begin
            if (w_last_round) begin
              r_state <= ST_DONE;
            end else begin
              r_round <= r_round + RND_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_round <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The last round's advance does not slide; the window is dead once DONE is reached.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        r_window[i] <= '0;
      end
    end else if (w_accept) begin
      r_window[r_load_cnt] <= i_in_data;
    end else if (w_step && !w_last_round) begin
      for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
        r_window[i] <= r_window[i+1];
      end
      r_window[BLOCK_WORDS-1] <= w_new;
    end
  end

  // Data and round index read as zero outside RUN so the K ROM sees a quiet address.
  assign o_in_ready   = (r_state == ST_LOAD);
  assign o_w_valid    = w_run;
  assign o_w_data     = w_run ? r_window[0] : '0;
  assign o_round_idx  = w_run ? r_round : '0;
  assign o_block_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: stimulus pushes the reference schedule per block,
// a negedge monitor pops and compares every consumed word and watches block_done.
module tb_sha256_msg_schedule;

  typedef logic [31:0] blk_t   [16];
  typedef logic [31:0] sched_t [64];
  typedef struct {
    logic [31:0] d;
    logic [5:0]  r;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, advance;
  logic [31:0] in_data;
  logic        o_in_ready, o_w_valid, o_block_done;
  logic [31:0] o_w_data;
  logic [5:0]  o_round_idx;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_seen = 0;
  int   done_exp  = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  sha256_msg_schedule dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (o_in_ready),
    .i_advance    (advance),
    .o_w_valid    (o_w_valid),
    .o_w_data     (o_w_data),
    .o_round_idx  (o_round_idx),
    .o_block_done (o_block_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void model(input blk_t m, output sched_t w);
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) begin
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},   32'(o_in_ready),   0);
    chk({tag, "_w_valid"},    32'(o_w_valid),    0);
    chk({tag, "_w_data"},     o_w_data,          0);
    chk({tag, "_round_idx"},  32'(o_round_idx),  0);
    chk({tag, "_block_done"}, 32'(o_block_done), 0);
  endtask

  // gap/stall are percentages; stall=0 holds advance high. reset_at<0 means run to completion.
  task automatic run_block(input blk_t m, input int gap, input int stall, input int reset_at,
                           input bit junk_same, input bit fix_abc);
    sched_t w;
    exp_t   e;
    int     k = 0;
    int     guard = 0;
    int     consumed = 0;
    bit     acc;
    model(m, w);
    for (int t = 0; t < 64; t++) begin
      e.d = w[t];
      e.r = 6'(t);
      if (fix_abc && t == 16) e.d = 32'h61626380;
      if (fix_abc && t == 17) e.d = 32'h000F0000;
      sb_q.push_back(e);
    end
    start = 1'b1;
    if (junk_same) begin
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
    end
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    chk("in_ready_in_load", 32'(o_in_ready), 1);
    while (k < 16 && guard < 300) begin
      if (gap > 0 && $urandom_range(99) < gap) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = m[k];
      end
      advance = (stall == 0) ? 1'b1 : 1'($urandom_range(1));
      acc = in_valid && o_in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    in_valid = 1'b0;
    if (k < 16) chk("load_timeout_words", 32'(k), 16);
    guard = 0;
    while (consumed < 64 && guard < 1000) begin
      if (reset_at >= 0 && consumed == reset_at) begin
        advance = 1'b0;
        start   = 1'b0;
        reset   = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("mid_reset");
        reset = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        chk_all_zero("post_reset_idle");
        return;
      end
      if (stall == 0) begin
        advance  = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
      end else begin
        advance  = ($urandom_range(99) < stall) ? 1'b0 : 1'b1;
        start    = ($urandom_range(9) == 0);
        in_valid = 1'($urandom_range(1));
        in_data  = $urandom;
      end
      acc = o_w_valid && advance;
      @(posedge clk); #1;
      if (acc) consumed++;
      guard++;
    end
    advance  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    if (consumed < 64) chk("run_timeout_rounds", 32'(consumed), 64);
    done_exp++;
    @(posedge clk); #1;
  endtask

  // Monitor: compares each word at the cycle it is consumed, checks holds during stalls.
  initial begin
    exp_t        e;
    bit          hold_v = 0;
    bit          done_pend = 0;
    logic [31:0] hold_d;
    logic [5:0]  hold_r;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 || reset === 1'bx) begin
        hold_v    = 0;
        done_pend = 0;
      end else begin
        if (o_block_done) done_seen++;
        if (done_pend) begin
          chk("block_done_pulse", 32'(o_block_done), 1);
          chk("w_valid_after_done", 32'(o_w_valid), 0);
          done_pend = 0;
        end else begin
          chk("block_done_spurious", 32'(o_block_done), 0);
        end
        if (hold_v && o_w_valid) begin
          chk("w_data_hold", o_w_data, hold_d);
          chk("round_idx_hold", 32'(o_round_idx), 32'(hold_r));
        end
        hold_v = 0;
        if (o_w_valid) begin
          if (advance) begin
            if (sb_q.size() == 0) chk("scoreboard_underflow", 0, 1);
            else begin
              e = sb_q.pop_front();
              chk("w_data", o_w_data, e.d);
              chk("round_idx", 32'(o_round_idx), 32'(e.r));
              if (e.r == 6'd63) done_pend = 1;
            end
          end else begin
            hold_v = 1;
            hold_d = o_w_data;
            hold_r = o_round_idx;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t m;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; advance = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(1));
      in_data  = $urandom;
      advance  = 1'($urandom_range(1));
      @(posedge clk); #1;
      chk_all_zero("idle");
    end
    in_valid = 1'b0;
    advance  = 1'b0;

    // "abc" padded block, advance held high.
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[0]  = 32'h61626380;
    m[15] = 32'h00000018;
    run_block(m, 0, 0, -1, 1'b0, 1'b1);

    // Random gaps and stalls, with stray start/in_valid during RUN.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) m[i] = $urandom;
      run_block(m, 40, 35, -1, 1'b0, 1'b0);
    end

    // Word presented alongside start must be dropped.
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    run_block(m, 20, 0, -1, 1'b1, 1'b0);

    // Reset at round 30, then a clean block.
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    run_block(m, 0, 0, 30, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    run_block(m, 10, 20, -1, 1'b0, 1'b0);

    // Back-to-back blocks at the earliest legal start.
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    run_block(m, 0, 0, -1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    run_block(m, 0, 0, -1, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 0);
    chk("block_done_count", 32'(done_seen), 32'(done_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
